// File: rtl/key_bank_editor_if.sv
// Bus bundle between key_bank_editor and its surroundings: button pulses,
// generator write port and the editor/key outputs.
interface key_bank_editor_if #(
  parameter int KEY_W  = 32,
  parameter int NKEYS  = 3,
  parameter int SLOT_W = 2,
  parameter int POS_W  = 4
);
  logic                   clr;
  logic                   lock;
  logic [SLOT_W-1:0]      sel;
  logic                   edit_p;
  logic                   next_p;
  logic                   inc_p;
  logic                   dec_p;
  logic [NKEYS-1:0]       gen_valid;
  logic [NKEYS*KEY_W-1:0] gen_key;
  logic                   typing;
  logic [POS_W-1:0]       digit;
  logic [KEY_W-1:0]       writing;
  logic [NKEYS*KEY_W-1:0] keys;
  logic                   commit_p;
  logic                   err_p;

  modport master (
    output clr, lock, sel, edit_p, next_p, inc_p, dec_p, gen_valid, gen_key,
    input  typing, digit, writing, keys, commit_p, err_p
  );

  modport slave (
    input  clr, lock, sel, edit_p, next_p, inc_p, dec_p, gen_valid, gen_key,
    output typing, digit, writing, keys, commit_p, err_p
  );
endinterface

// File: rtl/key_bank_editor.sv
// Key register bank with a decimal digit-by-digit editor and a generator write port.
// Define KEY_PRELOAD_EN to start editing from the stored key (serial binary-to-BCD load).
module key_bank_editor #(
  parameter int KEY_W  = 32,
  parameter int NDIG   = 10,
  parameter int NKEYS  = 3,
  parameter int SLOT_W = 2,
  parameter int POS_W  = 4
) (
  input logic              clk,
  input logic              rst,
  key_bank_editor_if.slave bus
);
  localparam int XW = KEY_W + 4;
  localparam logic [XW-1:0] KEY_MAX_X = {4'd0, {KEY_W{1'b1}}};

`ifdef KEY_PRELOAD_EN
  localparam int CNT_W = $clog2(KEY_W);
  typedef enum logic [1:0] {IDLE, LOAD, EDIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, EDIT} state_t;
`endif

  function automatic logic [XW-1:0] pow10(input int n);
    logic [XW-1:0] r;
    r = XW'(1);
    for (int i = 0; i < NDIG; i++)
      if (i < n) r = r * XW'(10);
    return r;
  endfunction

  logic [XW-1:0] p10 [NDIG];
  for (genvar g = 0; g < NDIG; g++) begin : g_p10
    assign p10[g] = pow10(g);
  end

  state_t            state_q, state_n;
  logic [KEY_W-1:0]  keys_q [NKEYS];
  logic [KEY_W-1:0]  keys_n [NKEYS];
  logic [KEY_W-1:0]  tot_q, tot_n;
  logic [3:0]        bcd_q [NDIG];
  logic [3:0]        bcd_n [NDIG];
  logic [POS_W-1:0]  cursor_q, cursor_n;
  logic [SLOT_W-1:0] eslot_q, eslot_n;
  logic              commit_q, commit_n;
  logic              err_q, err_n;

  logic [3:0]        d;
  logic [XW-1:0]     p;
  logic [XW-1:0]     tot_x;
  logic [XW-1:0]     dp;

  assign d     = bcd_q[cursor_q];
  assign p     = p10[cursor_q];
  assign tot_x = {4'd0, tot_q};
  assign dp    = XW'(d) * p;

`ifdef KEY_PRELOAD_EN
  logic [KEY_W-1:0] bin_q, bin_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       adj [NDIG];
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    assign adj[g] = (bcd_q[g] >= 4'd5) ? bcd_q[g] + 4'd3 : bcd_q[g];
  end
`endif

  // Generator writes first, then the editor; a gen write to the slot being edited is refused.
  always_comb begin
    state_n  = state_q;
    keys_n   = keys_q;
    tot_n    = tot_q;
    bcd_n    = bcd_q;
    cursor_n = cursor_q;
    eslot_n  = eslot_q;
    commit_n = 1'b0;
    err_n    = 1'b0;
`ifdef KEY_PRELOAD_EN
    bin_n    = bin_q;
    cnt_n    = cnt_q;
`endif

    for (int i = 0; i < NKEYS; i++) begin
      if (bus.gen_valid[i]) begin
        if (state_q != IDLE && eslot_q == SLOT_W'(i)) err_n = 1'b1;
        else keys_n[i] = bus.gen_key[i*KEY_W +: KEY_W];
      end
    end

    if (bus.clr) begin
      for (int i = 0; i < NKEYS; i++) keys_n[i] = '0;
      for (int j = 0; j < NDIG; j++) bcd_n[j] = 4'd0;
      state_n  = IDLE;
      tot_n    = '0;
      cursor_n = '0;
      err_n    = 1'b0;
    end else if (bus.lock) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.edit_p) begin
            eslot_n  = bus.sel;
            cursor_n = '0;
            if (int'(bus.sel) >= NKEYS) begin
              err_n = 1'b1;
            end else begin
              for (int j = 0; j < NDIG; j++) bcd_n[j] = 4'd0;
              tot_n = '0;
`ifdef KEY_PRELOAD_EN
              state_n = LOAD;
              bin_n   = keys_n[bus.sel];
              cnt_n   = '0;
`else
              state_n = EDIT;
`endif
            end
          end
        end
`ifdef KEY_PRELOAD_EN
        // One shift-add-3 step per cycle, MSB first.
        LOAD: begin
          bcd_n[0] = {adj[0][2:0], bin_q[KEY_W-1]};
          for (int j = 1; j < NDIG; j++) bcd_n[j] = {adj[j][2:0], adj[j-1][3]};
          bin_n = bin_q << 1;
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_W-1)) begin
            state_n = EDIT;
            tot_n   = keys_q[eslot_q];
          end
        end
`endif
        EDIT: begin
          if (bus.edit_p) begin
            keys_n[eslot_q] = '0;
            state_n         = IDLE;
          end else if (bus.next_p) begin
            if (cursor_q == POS_W'(NDIG-1)) begin
              keys_n[eslot_q] = tot_q;
              commit_n        = 1'b1;
              state_n         = IDLE;
            end else begin
              cursor_n = cursor_q + POS_W'(1);
            end
          end else if (bus.inc_p) begin
            if (d == 4'd9 || (tot_x + p) > KEY_MAX_X) begin
              bcd_n[cursor_q] = 4'd0;
              tot_n           = KEY_W'(tot_x - dp);
            end else begin
              bcd_n[cursor_q] = d + 4'd1;
              tot_n           = KEY_W'(tot_x + p);
            end
          end else if (bus.dec_p) begin
            if (d != 4'd0) begin
              bcd_n[cursor_q] = d - 4'd1;
              tot_n           = KEY_W'(tot_x - p);
            end else if ((tot_x + p * XW'(9)) <= KEY_MAX_X) begin
              bcd_n[cursor_q] = 4'd9;
              tot_n           = KEY_W'(tot_x + p * XW'(9));
            end else begin
              err_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      keys_q   <= '{default: '0};
      tot_q    <= '0;
      bcd_q    <= '{default: '0};
      cursor_q <= '0;
      eslot_q  <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef KEY_PRELOAD_EN
      bin_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_n;
      keys_q   <= keys_n;
      tot_q    <= tot_n;
      bcd_q    <= bcd_n;
      cursor_q <= cursor_n;
      eslot_q  <= eslot_n;
      commit_q <= commit_n;
      err_q    <= err_n;
`ifdef KEY_PRELOAD_EN
      bin_q    <= bin_n;
      cnt_q    <= cnt_n;
`endif
    end
  end

  assign bus.typing   = (state_q != IDLE);
  assign bus.digit    = cursor_q;
  assign bus.writing  = tot_q;
  assign bus.commit_p = commit_q;
  assign bus.err_p    = err_q;
  for (genvar g = 0; g < NKEYS; g++) begin : g_keys
    assign bus.keys[g*KEY_W +: KEY_W] = keys_q[g];
  end
endmodule
